bin_to_bcd_serial: RTL and testbench
====================================

// Module: bin_to_bcd_serial
// PURPOSE
//  Sequential double-dabble converter: binary value -> packed BCD digits for the
//  seven-segment serial driver directly downstream. One bit per clock, so it
//  needs no wide combinational adder chain. Valid/ready on the input side;
//  a one-cycle out_valid strobe marks each new held result.
// PARAMETERS
//  IN_W    12  binary input width (bits)
//  DIGITS  4   BCD digits produced (4 bits each)
//  CNT_W   4   bit-counter width; must hold IN_W-1 ($clog2(IN_W))
// PORTS
//  clk        in   1           rising-edge clock
//  rst_n      in   1           asynchronous active-low reset
//  in_valid   in   1           in_bin is valid
//  in_ready   out  1           converter idle; accepts when in_valid & in_ready
//  in_bin     in   IN_W        unsigned binary value
//  out_valid  out  1           one-cycle strobe: out_bcd/out_ovf updated
//  out_bcd    out  4*DIGITS    packed BCD, digit 0 (ones) in [3:0]; held between strobes
//  out_ovf    out  1           value exceeded 10^DIGITS-1; out_bcd = low digits only
//  out_blank  out  DIGITS      leading-zero blank mask (only with BCD_BLANK_EN)
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, in_ready=1, out_valid=0, out_bcd=0,
//   out_ovf=0, out_blank=0, counter=0, shift/BCD work regs=0.
//  FSM IDLE -> SHIFT -> DONE -> IDLE.
//   IDLE : in_ready=1. On in_valid&in_ready: load shreg<=in_bin, work<=0, cnt<=0,
//          ovf_acc<=0, go SHIFT. in_bin sampled only on the accept edge.
//   SHIFT: in_ready=0. Each cycle: every work digit >=5 gets +3 (4-bit result),
//          then {carry,work,shreg} shifts left 1; carry out of top digit ORs into
//          ovf_acc. cnt increments; after cnt==IN_W-1 cycle go DONE (IN_W cycles).
//   DONE : out_bcd<=work, out_ovf<=ovf_acc, out_valid=1 for this one cycle,
//          go IDLE. in_ready=0 in DONE.
//  Latency: accept edge to out_valid high = IN_W+1 clocks; throughput one
//   conversion per IN_W+2 clocks. in_valid during SHIFT/DONE is ignored (not lost
//   by converter: upstream must hold until in_ready).
//  Digits >9 never appear in out_bcd. Input 0 -> all-zero digits, ovf=0.
//  Max input 2^IN_W-1: with defaults 4095 -> 0x4095, ovf=0.
//  No back-pressure on output: downstream samples out_bcd any time; value is
//   stable except on the out_valid cycle edge.
//  Reset mid-conversion: abort immediately; outputs return to reset values.
//  in_valid asserted continuously: back-to-back conversions, one per IN_W+2 clk.
// CONFIGURATION
//  `BCD_BLANK_EN defined: in DONE, out_blank[i]<=1 for every digit i>0 whose
//   value and all higher digits are zero (digit 0 never blanked); updated with
//   out_bcd. Driver uses it to send an all-off segment pattern.
//  Not defined: out_blank tied to 0; no extra registers.
// STRUCTURE
//  Package bcd_pkg: state encoding (ST_IDLE, ST_SHIFT, ST_DONE), DIGIT_W=4,
//   ADJ_THRESH=5, ADJ_ADD=3.
//  Sub-module bcd_digit_adj: combinational 4-bit "if >=5 add 3", instantiated
//   DIGITS times via generate. Top holds FSM, counter, shift/work regs.
// TESTING
//  1 reset mid-SHIFT (cnt=5) -> all outputs reset vals same cycle, in_ready=1 after release.
//  2 in_bin=0x0FF (255) -> out_valid 13 clk after accept, out_bcd=0x0255, ovf=0.
//  3 in_bin=0xFFF (4095) -> out_bcd=0x4095, ovf=0; DIGITS=3 build -> 0x095, ovf=1.
//  4 in_valid held high, values 9 then 10 -> strobes 14 clk apart, 0x0009 then 0x0010.
//  5 in_bin=7 with BCD_BLANK_EN -> out_blank=4'b1110; without -> 4'b0000.
//  6 exhaustive 0..4095 vs reference model -> all digits match, no digit >9.

Source files
------------

// File: rtl/bcd_pkg.sv
// bcd_pkg: shared encodings and constants for the serial binary-to-BCD converter.
package bcd_pkg;
   typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;
   localparam int DIGIT_W    = 4;
   localparam int ADJ_THRESH = 5;
   localparam int ADJ_ADD    = 3;
endpackage

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj: one double-dabble digit correction (add 3 when digit >= 5).
module bcd_digit_adj
   import bcd_pkg::*;
(
   input  logic [DIGIT_W-1:0] d,
   output logic [DIGIT_W-1:0] q
);
   assign q = (d >= DIGIT_W'(ADJ_THRESH)) ? d + DIGIT_W'(ADJ_ADD) : d;
endmodule

// File: rtl/bin_to_bcd_serial.sv
// bin_to_bcd_serial: one-bit-per-clock double-dabble binary to packed BCD converter.
// Optional leading-zero blank mask enabled by defining BCD_BLANK_EN.
module bin_to_bcd_serial
   import bcd_pkg::*;
#(
   parameter int IN_W   = 12,
   parameter int DIGITS = 4,
   parameter int CNT_W  = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [IN_W-1:0]           in_bin,
   output logic                      out_valid,
   output logic [DIGIT_W*DIGITS-1:0] out_bcd,
   output logic                      out_ovf,
   output logic [DIGITS-1:0]         out_blank
);
   localparam int BW = DIGIT_W*DIGITS;
   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic [IN_W-1:0]   shreg;
   logic [BW-1:0]     work;
   logic [BW-1:0]     adj;
   logic              ovf_acc;
   assign in_ready = (state == ST_IDLE);
   for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      bcd_digit_adj u_adj (
         .d(work[g*DIGIT_W +: DIGIT_W]),
         .q(adj[g*DIGIT_W +: DIGIT_W])
      );
   end
`ifdef BCD_BLANK_EN
   logic [DIGITS-1:0] blank_nx;
   logic              zero;
   // A digit is blank when it and every digit above it are zero; ones digit always shown.
   always_comb begin
      blank_nx = '0;
      zero     = 1'b1;
      for (int i = DIGITS-1; i > 0; i--) begin
         zero        = zero & (work[i*DIGIT_W +: DIGIT_W] == '0);
         blank_nx[i] = zero;
      end
   end
`else
   assign out_blank = '0;
`endif
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         shreg     <= '0;
         work      <= '0;
         ovf_acc   <= 1'b0;
         out_valid <= 1'b0;
         out_bcd   <= '0;
         out_ovf   <= 1'b0;
`ifdef BCD_BLANK_EN
         out_blank <= '0;
`endif
      end else begin
         out_valid <= 1'b0;
         case (state)
            ST_IDLE: if (in_valid) begin
               shreg   <= in_bin;
               work    <= '0;
               cnt     <= '0;
               ovf_acc <= 1'b0;
               state   <= ST_SHIFT;
            end
            ST_SHIFT: begin
               // Bit shifted out of the top digit means the value needs more digits.
               {work, shreg} <= {adj[BW-2:0], shreg, 1'b0};
               ovf_acc       <= ovf_acc | adj[BW-1];
               cnt           <= cnt + 1'b1;
               if (cnt == CNT_W'(IN_W-1)) state <= ST_DONE;
            end
            ST_DONE: begin
               out_bcd   <= work;
               out_ovf   <= ovf_acc;
               out_valid <= 1'b1;
`ifdef BCD_BLANK_EN
               out_blank <= blank_nx;
`endif
               state     <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_bin_to_bcd_serial.sv
// tb_bin_to_bcd_serial: directed and exhaustive checks of the serial BCD converter,
// with a second 3-digit instance for overflow behaviour.
module tb_bin_to_bcd_serial;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [11:0] in_bin = '0;
   logic        out_valid;
   logic [15:0] out_bcd;
   logic        out_ovf;
   logic [3:0]  out_blank;
   logic        in_ready3;
   logic        out_valid3;
   logic [11:0] out_bcd3;
   logic        out_ovf3;
   logic [2:0]  out_blank3;
   int          tests = 0;
   int          fails = 0;

   always #5 clk = ~clk;

   bin_to_bcd_serial dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_bin(in_bin),
      .out_valid(out_valid), .out_bcd(out_bcd), .out_ovf(out_ovf), .out_blank(out_blank)
   );

   bin_to_bcd_serial #(.IN_W(12), .DIGITS(3), .CNT_W(4)) dut3 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready3), .in_bin(in_bin),
      .out_valid(out_valid3), .out_bcd(out_bcd3), .out_ovf(out_ovf3), .out_blank(out_blank3)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] model(input int v);
      return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
   endfunction

   // Called and returns aligned to 1 time unit after a rising edge.
   task automatic convert(input logic [11:0] v, output int lat);
      int k;
      k = 0;
      while (!in_ready && k < 40) begin
         @(posedge clk); #1;
         k++;
      end
      check("ready_wait", 32'(in_ready), 1);
      in_valid = 1'b1;
      in_bin   = v;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   initial begin
      int lat, n, t1, t2;
      logic [15:0] b1, b2, exp;
      logic bad;
      #12;
      check("rst_ready", 32'(in_ready), 1);
      check("rst_valid", 32'(out_valid), 0);
      check("rst_bcd", 32'(out_bcd), 0);
      check("rst_ovf", 32'(out_ovf), 0);
      check("rst_blank", 32'(out_blank), 0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      convert(12'h0FF, lat);
      check("lat_255", lat, 13);
      check("bcd_255", 32'({out_ovf, out_bcd}), 32'h0255);
      @(posedge clk); #1;
      check("strobe_len", 32'(out_valid), 0);
      check("hold_255", 32'(out_bcd), 32'h0255);

      convert(12'hFFF, lat);
      check("bcd_4095", 32'({out_ovf, out_bcd}), 32'h4095);
      check("bcd3_4095", 32'({out_ovf3, out_bcd3}), 32'h1095);
      convert(12'd1000, lat);
      check("bcd_1000", 32'({out_ovf, out_bcd}), 32'h1000);
      check("bcd3_1000", 32'({out_ovf3, out_bcd3}), 32'h1000);
      convert(12'd999, lat);
      check("bcd3_999", 32'({out_ovf3, out_bcd3}), 32'h0999);

      convert(12'd7, lat);
`ifdef BCD_BLANK_EN
      check("blank_7", 32'(out_blank), 32'b1110);
      check("blank3_7", 32'(out_blank3), 32'b110);
`else
      check("blank_7", 32'(out_blank), 0);
      check("blank3_7", 32'(out_blank3), 0);
`endif

      // Reset in the middle of a shift sequence
      in_valid = 1'b1;
      in_bin   = 12'd123;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("busy_ready", 32'(in_ready), 0);
      rst_n = 1'b0;
      #1;
      check("mid_rst_ready", 32'(in_ready), 1);
      check("mid_rst_bcd", 32'(out_bcd), 0);
      check("mid_rst_valid", 32'(out_valid), 0);
      check("mid_rst_blank", 32'(out_blank), 0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      check("post_rst_ready", 32'(in_ready), 1);
      convert(12'd123, lat);
      check("bcd_123", 32'({out_ovf, out_bcd}), 32'h0123);

      // Continuous in_valid: back-to-back conversions
      in_valid = 1'b1;
      in_bin   = 12'd9;
      @(posedge clk); #1;
      in_bin = 12'd10;
      n = 0; t1 = 0; t2 = 0; b1 = '0; b2 = '0;
      while (t2 == 0 && n < 60) begin
         @(posedge clk); #1;
         n++;
         if (out_valid) begin
            if (t1 == 0) begin
               t1 = n;
               b1 = out_bcd;
            end else begin
               t2 = n;
               b2 = out_bcd;
            end
         end
      end
      in_valid = 1'b0;
      check("b2b_lat", t1, 13);
      check("b2b_gap", t2 - t1, 14);
      check("b2b_9", 32'(b1), 32'h0009);
      check("b2b_10", 32'(b2), 32'h0010);

      for (int v = 0; v < 4096; v++) begin
         convert(12'(v), lat);
         exp = model(v);
         bad = 1'b0;
         for (int d = 0; d < 4; d++) bad = bad | (out_bcd[d*4 +: 4] > 4'd9);
         check("exh_lat", lat, 13);
         check("exh_bcd", 32'({out_ovf, out_bcd}), 32'(exp));
         check("exh_digit", 32'(bad), 0);
         check("exh3_bcd", 32'({out_ovf3, out_bcd3}), {19'd0, v > 999, exp[11:0]});
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
